csc_pipe: RTL and testbench

- Parametrised, pipelined colour-space converter for the DIP video stream.
- Successor to the fixed RGB-to-YCbCr block: configurable sample width and four runtime modes (BT.601 forward, BT.709 forward, BT.601 inverse, bypass).
- Frame-safe mode switching, rounding and saturation.
- Sits between the sensor/stream source and downstream filters, using the same vsync/href/3-channel stream format.

---
 rtl/csc_pkg.sv | 39 +++
 rtl/csc_mac3.sv | 82 ++++++++
 rtl/csc_pipe.sv | 84 ++++++++
 tb/tb_csc_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared types and constants for the colour-space converter pipeline.
// Coefficients are Q.8 signed; each matrix row produces one output channel.
package csc_pkg;

  localparam int LAT        = 3;
  localparam int FRAC       = 8;
  localparam int CSC_COEF_W = 12;

  typedef enum logic [1:0] {
    CSC_601_FWD = 2'd0,
    CSC_709_FWD = 2'd1,
    CSC_601_INV = 2'd2,
    CSC_BYPASS  = 2'd3
  } csc_mode_e;

  typedef logic [2:0][CSC_COEF_W-1:0]      coef_row_t;
  typedef logic [2:0][2:0][CSC_COEF_W-1:0] coef_mat_t;

  function automatic coef_row_t row3(int a, int b, int c);
    coef_row_t r;
    r[0] = CSC_COEF_W'(a);
    r[1] = CSC_COEF_W'(b);
    r[2] = CSC_COEF_W'(c);
    return r;
  endfunction

  // Row index 0/1/2 selects output channel c0/c1/c2.
  function automatic coef_mat_t get_coefs(csc_mode_e mode);
    coef_mat_t m;
    case (mode)
      CSC_601_FWD: m = {row3(128, -107, -21), row3(-43, -85, 128), row3(77, 150, 29)};
      CSC_709_FWD: m = {row3(128, -116, -12), row3(-29, -99, 128), row3(54, 183, 19)};
      CSC_601_INV: m = {row3(256, 454, 0), row3(256, -88, -183), row3(256, 0, 359)};
      default:     m = {row3(0, 0, 256), row3(0, 256, 0), row3(256, 0, 0)};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/csc_mac3.sv
// One output channel of the converter: offset removal and multiply,
// accumulate with offset and rounding, then clamp and href gating.
module csc_mac3
  import csc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = CSC_COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  csc_mode_e         mode,
  input  csc_mode_e         mode_s1,
  input  logic              href_s2,
  input  logic              ofs_row,
  input  coef_row_t         coef_row,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  output logic [DATA_W-1:0] y
);

  localparam int X_W    = DATA_W + 1;
  localparam int PROD_W = X_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;

  localparam logic signed [X_W-1:0]   OFS_X  = X_W'(1) << (DATA_W - 1);
  localparam logic signed [ACC_W-1:0] OFS_Q8 = ACC_W'(1) << (DATA_W - 1 + FRAC);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX  = ACC_W'((1 << DATA_W) - 1);

  logic signed [X_W-1:0]    x [3];
  logic signed [COEF_W-1:0] k [3];
  logic signed [PROD_W-1:0] p_d [3];
  logic signed [PROD_W-1:0] p_q [3];
  logic signed [ACC_W-1:0]  ofs_add, acc_d, acc_q, res;
  logic [DATA_W-1:0]        y_d;

  always_comb begin
    x[0] = signed'({1'b0, c0});
    x[1] = signed'({1'b0, c1});
    x[2] = signed'({1'b0, c2});
    // Chroma inputs are offset-binary in the inverse direction.
    if (mode == CSC_601_INV) begin
      x[1] = signed'({1'b0, c1}) - OFS_X;
      x[2] = signed'({1'b0, c2}) - OFS_X;
    end
    for (int i = 0; i < 3; i++) begin
      k[i]   = COEF_W'(signed'(coef_row[i]));
      p_d[i] = PROD_W'(k[i]) * PROD_W'(x[i]);
    end
  end

  always_comb begin
    ofs_add = '0;
    if (ofs_row && (mode_s1 == CSC_601_FWD || mode_s1 == CSC_709_FWD))
      ofs_add = OFS_Q8;
    acc_d = ACC_W'(p_q[0]) + ACC_W'(p_q[1]) + ACC_W'(p_q[2]) + ofs_add + RND;
  end

  always_comb begin
    res = acc_q >>> FRAC;
    if (res < 0)
      y_d = '0;
    else if (res > Y_MAX)
      y_d = '1;
    else
      y_d = res[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) p_q[i] <= '0;
      acc_q <= '0;
      y     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) p_q[i] <= p_d[i];
      acc_q <= acc_d;
      y     <= href_s2 ? y_d : '0;
    end
  end

endmodule

// File: rtl/csc_pipe.sv
// Three-stage colour-space converter with frame-synchronous mode switching.
// The mode is latched on each vsync rise and carried down the pipe with the pixels.
module csc_pipe
  import csc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = CSC_COEF_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        cfg_mode,
  input  logic              per_img_vsync,
  input  logic              per_img_href,
  input  logic [DATA_W-1:0] per_img_c0,
  input  logic [DATA_W-1:0] per_img_c1,
  input  logic [DATA_W-1:0] per_img_c2,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_c0,
  output logic [DATA_W-1:0] post_img_c1,
  output logic [DATA_W-1:0] post_img_c2,
  output logic [1:0]        mode_active
);

  csc_mode_e mode_lat, mode_eff, mode_s1, mode_s2;
  coef_mat_t coefs;
  logic      vsync_d;
  logic [1:0] vs_pipe, hr_pipe;
  logic [DATA_W-1:0] y [3];

  // The pixel on the vsync-rise cycle already uses the newly captured mode.
  always_comb begin
    mode_eff = (per_img_vsync && !vsync_d) ? csc_mode_e'(cfg_mode) : mode_lat;
    coefs    = get_coefs(mode_eff);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vsync_d        <= 1'b0;
      mode_lat       <= CSC_601_FWD;
      mode_s1        <= CSC_601_FWD;
      mode_s2        <= CSC_601_FWD;
      vs_pipe        <= '0;
      hr_pipe        <= '0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      mode_active    <= '0;
    end else begin
      vsync_d        <= per_img_vsync;
      mode_lat       <= mode_eff;
      mode_s1        <= mode_eff;
      mode_s2        <= mode_s1;
      vs_pipe        <= {vs_pipe[0], per_img_vsync};
      hr_pipe        <= {hr_pipe[0], per_img_href};
      post_img_vsync <= vs_pipe[1];
      post_img_href  <= hr_pipe[1];
      mode_active    <= mode_s2;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_ch
    csc_mac3 #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W)
    ) u_mac (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .mode    (mode_eff),
      .mode_s1 (mode_s1),
      .href_s2 (hr_pipe[1]),
      .ofs_row (r != 0),
      .coef_row(coefs[r]),
      .c0      (per_img_c0),
      .c1      (per_img_c1),
      .c2      (per_img_c2),
      .y       (y[r])
    );
  end

  assign post_img_c0 = y[0];
  assign post_img_c1 = y[1];
  assign post_img_c2 = y[2];

endmodule

// File: tb/tb_csc_pipe.sv
// Scoreboard bench for csc_pipe: a per-cycle reference model predicts every
// output cycle, and a negedge monitor compares the DUT against the queue.
module tb_csc_pipe;

  localparam int DW = 8;

  typedef struct {
    logic vs;
    logic hr;
    int   c0;
    int   c1;
    int   c2;
    int   mode;
  } rec_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic          per_img_vsync = 1'b0, per_img_href = 1'b0;
  logic [DW-1:0] per_img_c0 = '0, per_img_c1 = '0, per_img_c2 = '0;
  logic          post_img_vsync, post_img_href;
  logic [DW-1:0] post_img_c0, post_img_c1, post_img_c2;
  logic [1:0]    mode_active;

  logic          vs10 = 1'b0, hr10 = 1'b0;
  logic [9:0]    c10 = '0;
  logic          o10_vs, o10_hr;
  logic [9:0]    o10_c0, o10_c1, o10_c2;
  logic [1:0]    o10_mode;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t q[$];
  rec_t zero_rec = '{vs: 1'b0, hr: 1'b0, c0: 0, c1: 0, c2: 0, mode: 0};

  // Reference model state: last vsync seen and the latched mode.
  logic m_vs  = 1'b0;
  int   m_lat = 0;

  int coef [4][3][3] = '{
    '{'{77, 150, 29},  '{-43, -85, 128},  '{128, -107, -21}},
    '{'{54, 183, 19},  '{-29, -99, 128},  '{128, -116, -12}},
    '{'{256, 0, 359},  '{256, -88, -183}, '{256, 454, 0}},
    '{'{256, 0, 0},    '{0, 256, 0},      '{0, 0, 256}}
  };

  always #5 sys_clk = ~sys_clk;

  csc_pipe #(.DATA_W(DW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cfg_mode      (cfg_mode),
    .per_img_vsync (per_img_vsync),
    .per_img_href  (per_img_href),
    .per_img_c0    (per_img_c0),
    .per_img_c1    (per_img_c1),
    .per_img_c2    (per_img_c2),
    .post_img_vsync(post_img_vsync),
    .post_img_href (post_img_href),
    .post_img_c0   (post_img_c0),
    .post_img_c1   (post_img_c1),
    .post_img_c2   (post_img_c2),
    .mode_active   (mode_active)
  );

  csc_pipe #(.DATA_W(10)) dut10 (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cfg_mode      (2'd0),
    .per_img_vsync (vs10),
    .per_img_href  (hr10),
    .per_img_c0    (c10),
    .per_img_c1    (c10),
    .per_img_c2    (c10),
    .post_img_vsync(o10_vs),
    .post_img_href (o10_hr),
    .post_img_c0   (o10_c0),
    .post_img_c1   (o10_c1),
    .post_img_c2   (o10_c2),
    .mode_active   (o10_mode)
  );

  task automatic check(string name, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Full-precision conversion: y = floor((sum(k*x) + offset + 128) / 256), clamped.
  function automatic int conv(int mode, int row, int a0, int a1, int a2);
    int ofs = 1 << (DW - 1);
    int x1 = a1;
    int x2 = a2;
    int s;
    if (mode == 2) begin
      x1 -= ofs;
      x2 -= ofs;
    end
    s = coef[mode][row][0] * a0 + coef[mode][row][1] * x1 + coef[mode][row][2] * x2;
    if (mode < 2 && row > 0) s += ofs * 256;
    s = (s + 128) >>> 8;
    if (s < 0) s = 0;
    if (s > (1 << DW) - 1) s = (1 << DW) - 1;
    return s;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, (1 << DW) - 1));
  endfunction

  task automatic drive(bit r, bit vs, bit hr, int a0, int a1, int a2, int cfg,
                       bit fix, int f0, int f1, int f2);
    rec_t e;
    sys_rst       = r;
    per_img_vsync = vs;
    per_img_href  = hr;
    per_img_c0    = DW'(a0);
    per_img_c1    = DW'(a1);
    per_img_c2    = DW'(a2);
    cfg_mode      = cfg[1:0];
    e = zero_rec;
    if (r) begin
      // Everything still in flight behind the current output is discarded.
      for (int i = 1; i < q.size(); i++) q[i] = zero_rec;
      m_vs  = 1'b0;
      m_lat = 0;
    end else begin
      if (vs && !m_vs) m_lat = cfg;
      m_vs   = vs;
      e.vs   = vs;
      e.hr   = hr;
      e.mode = m_lat;
      if (hr) begin
        e.c0 = fix ? f0 : conv(m_lat, 0, a0, a1, a2);
        e.c1 = fix ? f1 : conv(m_lat, 1, a0, a1, a2);
        e.c2 = fix ? f2 : conv(m_lat, 2, a0, a1, a2);
      end
    end
    q.push_back(e);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic step(bit r, bit vs, bit hr, int a0, int a1, int a2, int cfg);
    drive(r, vs, hr, a0, a1, a2, cfg, 1'b0, 0, 0, 0);
  endtask

  task automatic frame(int cfg, int rows, int cols, int cfg_mid);
    int c = cfg;
    step(0, 1, 0, 0, 0, 0, c);
    for (int r = 0; r < rows; r++) begin
      if (r == rows / 2) c = cfg_mid;
      for (int i = 0; i < cols; i++) step(0, 1, 1, rnd(), rnd(), rnd(), c);
      repeat (3) step(0, 1, 0, rnd(), rnd(), rnd(), c);
    end
    step(0, 0, 0, 0, 0, 0, c);
  endtask

  // Monitor: one expected record per output cycle.
  initial begin
    rec_t e;
    @(posedge sys_clk);
    forever begin
      @(negedge sys_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("vsync", 32'(post_img_vsync), int'(e.vs));
        check("href",  32'(post_img_href),  int'(e.hr));
        check("c0",    32'(post_img_c0),    e.c0);
        check("c1",    32'(post_img_c1),    e.c1);
        check("c2",    32'(post_img_c2),    e.c2);
        check("mode_active", 32'(mode_active), e.mode);
      end
    end
  end

  initial begin
    q.push_back(zero_rec);
    q.push_back(zero_rec);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);

    // Directed BT.601 forward: white and saturating red.
    step(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 255, 255, 255, 0, 1'b1, 255, 128, 128);
    drive(0, 1, 1, 255, 0, 0, 0, 1'b1, 77, 85, 255);
    repeat (4) step(0, 1, 1, rnd(), rnd(), rnd(), 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Directed BT.601 inverse: G clamps at zero.
    step(0, 1, 0, 0, 0, 0, 2);
    drive(0, 1, 1, 0, 128, 255, 2, 1'b1, 178, 0, 0);
    repeat (4) step(0, 1, 1, rnd(), rnd(), rnd(), 2);
    step(0, 0, 0, 0, 0, 0, 2);

    // Mid-frame cfg change is held off until the next frame.
    frame(0, 4, 64, 1);
    frame(1, 4, 64, 1);

    // Full 512x4 frames in every mode, back to back.
    frame(0, 4, 512, 0);
    frame(1, 4, 512, 1);
    frame(2, 4, 512, 2);
    frame(3, 4, 512, 3);

    // Reset mid-row, then href without vsync runs in mode 0.
    step(0, 1, 0, 0, 0, 0, 2);
    repeat (10) step(0, 1, 1, rnd(), rnd(), rnd(), 2);
    step(1, 1, 1, rnd(), rnd(), rnd(), 2);
    repeat (20) step(0, 0, 1, rnd(), rnd(), rnd(), 2);
    step(0, 0, 0, 0, 0, 0, 2);
    frame(2, 2, 16, 3);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge sys_clk);
    if (q.size() > 0) check("drain", 32'(q.size()), 0);

    // 10-bit instance: white in BT.601 forward.
    vs10 = 1'b1;
    hr10 = 1'b1;
    c10  = 10'd1023;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("w10_href", 32'(o10_hr), 1);
    check("w10_vsync", 32'(o10_vs), 1);
    check("w10_c0", 32'(o10_c0), 1023);
    check("w10_c1", 32'(o10_c1), 512);
    check("w10_c2", 32'(o10_c2), 512);
    check("w10_mode", 32'(o10_mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
